// File: rtl/fb_scanout_pkg.sv
// rtl/fb_scanout_pkg.sv - fetch FSM state type and derived-parameter helpers for fb_scanout
package fb_scanout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int calc_wpl(input int h_active, input int scale, input int bpp, input int data_w);
        return h_active / scale * bpp / data_w;
    endfunction

    function automatic int calc_ppw(input int data_w, input int bpp);
        return data_w / bpp;
    endfunction

endpackage

// File: rtl/fb_scanout_fifo.sv
// rtl/fb_scanout_fifo.sv - prefetch FIFO with synchronous flush and occupancy count
module fb_scanout_fifo
    import fb_scanout_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign do_push    = push_i && (count_q != CNT_W'(FIFO_DEPTH));
    assign do_pop     = pop_i && (count_q != '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - framebuffer scanout: line fetch FSM, prefetch FIFO, pixel serialiser/scaler.
// Optional saturating underflow counter enabled by FB_SCANOUT_UFLOW_CNT_EN.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int BPP        = 1,
    parameter int SCALE      = 4,
    parameter int H_ACTIVE   = 640,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              in_display,
    input  logic              line_start,
    input  logic              frame_start,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data,
    output logic [BPP-1:0]    pix_out,
    output logic              underflow,
    output logic [15:0]       underflow_cnt
);

    localparam int WPL   = calc_wpl(H_ACTIVE, SCALE, BPP, DATA_W);
    localparam int PPW   = calc_ppw(DATA_W, BPP);
    localparam int IDX_W = clog2(WPL + 1);
    localparam int REP_W = (SCALE > 1) ? clog2(SCALE) : 1;
    localparam int SFT_W = (PPW > 1) ? clog2(PPW) : 1;
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0]  WPL_V   = IDX_W'(WPL);
    localparam logic [ADDR_W-1:0] WPL_A   = ADDR_W'(WPL);
    localparam logic [ADDR_W-1:0] BASE_V  = ADDR_W'(BASE_ADDR);
    localparam logic [REP_W-1:0]  REP_MAX = REP_W'(SCALE - 1);
    localparam logic [SFT_W-1:0]  SFT_MAX = SFT_W'(PPW - 1);
    localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(FIFO_DEPTH);

    fetch_state_e      state_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [REP_W-1:0]  vrep_q;
    logic              first_line_q;
    logic              discard_q;

    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;

    assign fifo_flush = line_start || frame_start;
    assign fifo_push  = (state_q == ST_WAIT) && rsp_valid && !discard_q;
    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;

    fb_scanout_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk50),
        .rst_i       (reset),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (rsp_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // Line/frame events are applied after the FSM step so they override word_idx and discard.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            word_idx_q   <= WPL_V;
            line_base_q  <= BASE_V;
            vrep_q       <= '0;
            first_line_q <= 1'b1;
            discard_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_flush && (word_idx_q < WPL_V) && (fifo_count < DEPTH_V)) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= line_base_q + ADDR_W'(word_idx_q);
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                        if (!discard_q) word_idx_q <= word_idx_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        state_q   <= ST_IDLE;
                        discard_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase

            if (frame_start) begin
                line_base_q  <= BASE_V;
                vrep_q       <= '0;
                first_line_q <= 1'b1;
                word_idx_q   <= WPL_V;
            end
            if (line_start) begin
                word_idx_q <= '0;
                if (frame_start || first_line_q) begin
                    first_line_q <= 1'b0;
                end else if (vrep_q == REP_MAX) begin
                    vrep_q      <= '0;
                    line_base_q <= line_base_q + WPL_A;
                end else begin
                    vrep_q <= vrep_q + 1'b1;
                end
            end
            if (fifo_flush && ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !rsp_valid))) begin
                discard_q <= 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [REP_W-1:0]  hrep_q, hrep_d;
    logic [SFT_W-1:0]  sft_q, sft_d;
    logic              need_load_q, need_load_d;
    logic [BPP-1:0]    pix_q, pix_d;
    logic              underflow_q, underflow_d;
    logic              uflow_evt;
    logic [DATA_W-1:0] cur_word;

    always_comb begin
        shreg_d     = shreg_q;
        hrep_d      = hrep_q;
        sft_d       = sft_q;
        need_load_d = need_load_q;
        pix_d       = pix_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        uflow_evt   = 1'b0;
        cur_word    = shreg_q;
        if (line_start) begin
            hrep_d      = '0;
            sft_d       = '0;
            need_load_d = 1'b1;
        end else if (pix_en && in_display) begin
            // An empty FIFO at a pop blanks the whole word span rather than replaying stale bits.
            if (need_load_q) begin
                fifo_pop  = !fifo_empty;
                uflow_evt = fifo_empty;
                cur_word  = fifo_empty ? '0 : fifo_data;
            end
            pix_d       = cur_word[BPP-1:0];
            need_load_d = 1'b0;
            shreg_d     = cur_word;
            if (hrep_q == REP_MAX) begin
                hrep_d  = '0;
                shreg_d = cur_word >> BPP;
                if (sft_q == SFT_MAX) begin
                    sft_d       = '0;
                    need_load_d = 1'b1;
                end else begin
                    sft_d = sft_q + 1'b1;
                end
            end else begin
                hrep_d = hrep_q + 1'b1;
            end
        end
        if (!in_display) pix_d = '0;
        if (uflow_evt) underflow_d = 1'b1;
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            shreg_q     <= '0;
            hrep_q      <= '0;
            sft_q       <= '0;
            need_load_q <= 1'b1;
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            hrep_q      <= hrep_d;
            sft_q       <= sft_d;
            need_load_q <= need_load_d;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    assign pix_out   = pix_q;
    assign underflow = underflow_q;

`ifdef FB_SCANOUT_UFLOW_CNT_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            ucnt_q <= '0;
        end else if (uflow_evt && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end
    assign underflow_cnt = ucnt_q;
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - directed self-checking bench for fb_scanout (BPP=1 and BPP=2 instances)
module tb_fb_scanout;

    localparam int LAT  = 4;
    localparam int LEAD = 40;
    localparam int H    = 640;

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0, in_display = 1'b0, line_start = 1'b0, frame_start = 1'b0;
    logic rdy_a = 1'b1, rdy_b = 1'b1;

    logic        req_valid_a, req_valid_b;
    logic [19:0] req_addr_a, req_addr_b;
    logic        ready_a, ready_b;
    logic        rsp_valid_a = 1'b0, rsp_valid_b = 1'b0;
    logic [15:0] rsp_data_a = '0, rsp_data_b = '0;
    logic [0:0]  pix_out_a;
    logic [1:0]  pix_out_b;
    logic        underflow_a, underflow_b;
    logic [15:0] ucnt_a, ucnt_b;

    logic [15:0] mem [64];
    logic [1:0]  cap_a [H];
    logic [1:0]  cap_b [H];
    logic [19:0] acc_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk50 = ~clk50;

    fb_scanout dut_a (
        .clk50(clk50), .reset(reset), .pix_en(pix_en), .in_display(in_display),
        .line_start(line_start), .frame_start(frame_start),
        .req_valid(req_valid_a), .req_addr(req_addr_a), .req_ready(ready_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
        .pix_out(pix_out_a), .underflow(underflow_a), .underflow_cnt(ucnt_a)
    );

    fb_scanout #(.BPP(2)) dut_b (
        .clk50(clk50), .reset(reset), .pix_en(pix_en), .in_display(in_display),
        .line_start(line_start), .frame_start(frame_start),
        .req_valid(req_valid_b), .req_addr(req_addr_b), .req_ready(ready_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .pix_out(pix_out_b), .underflow(underflow_b), .underflow_cnt(ucnt_b)
    );

    // Memory models: data captured at accept, response LAT+1 cycles later; they ignore reset.
    logic pend_a = 1'b0, pend_b = 1'b0;
    int   cnt_a = 0, cnt_b = 0;
    logic [15:0] dat_a = '0, dat_b = '0;
    assign ready_a = rdy_a && !pend_a;
    assign ready_b = rdy_b && !pend_b;

    always @(posedge clk50) begin
        rsp_valid_a <= 1'b0;
        if (pend_a) begin
            if (cnt_a == 0) begin
                rsp_valid_a <= 1'b1;
                rsp_data_a  <= dat_a;
                pend_a      <= 1'b0;
            end else cnt_a <= cnt_a - 1;
        end else if (req_valid_a && ready_a) begin
            pend_a <= 1'b1;
            cnt_a  <= LAT;
            dat_a  <= mem[req_addr_a[5:0]];
            acc_q.push_back(req_addr_a);
        end
    end

    always @(posedge clk50) begin
        rsp_valid_b <= 1'b0;
        if (pend_b) begin
            if (cnt_b == 0) begin
                rsp_valid_b <= 1'b1;
                rsp_data_b  <= dat_b;
                pend_b      <= 1'b0;
            end else cnt_b <= cnt_b - 1;
        end else if (req_valid_b && ready_b) begin
            pend_b <= 1'b1;
            cnt_b  <= LAT;
            dat_b  <= mem[req_addr_b[5:0]];
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    endtask

    task automatic pulse_frame();
        @(negedge clk50); frame_start = 1'b1;
        @(negedge clk50); frame_start = 1'b0;
    endtask

    task automatic run_line(input bit with_frame);
        @(negedge clk50); line_start = 1'b1; frame_start = with_frame;
        @(negedge clk50); line_start = 1'b0; frame_start = 1'b0;
        repeat (LEAD) @(negedge clk50);
        pix_en = 1'b1; in_display = 1'b1;
        for (int i = 0; i < H; i++) begin
            @(negedge clk50);
            cap_a[i] = {1'b0, pix_out_a};
            cap_b[i] = pix_out_b;
        end
        pix_en = 1'b0; in_display = 1'b0;
        repeat (4) @(negedge clk50);
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (acc_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk50);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        repeat (3) @(negedge clk50);
        n_checks++; if (req_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset req_valid: got %0b expected 0", req_valid_a); end
        n_checks++; if (req_addr_a !== 20'h0) begin n_fail++; $display("FAIL reset req_addr: got %0h expected 0", req_addr_a); end
        n_checks++; if (pix_out_a !== 1'b0) begin n_fail++; $display("FAIL reset pix_out: got %0b expected 0", pix_out_a); end
        n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL reset underflow: got %0b expected 0", underflow_a); end
        n_checks++; if (ucnt_a !== 16'h0) begin n_fail++; $display("FAIL reset underflow_cnt: got %0d expected 0", ucnt_a); end
        reset = 1'b0;
        repeat (6) @(negedge clk50);
        n_checks++; if (req_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset idle req_valid: got %0b expected 0", req_valid_a); end
    endtask

    task automatic test_first_word();
        logic [1:0] exp;
        clear_mem();
        mem[0] = 16'h0001;
        pulse_frame();
        run_line(1'b0);
        for (int i = 0; i < 64; i++) begin
            exp = (i < 4) ? 2'd1 : 2'd0;
            n_checks++;
            if (cap_a[i] !== exp) begin n_fail++; $display("FAIL first_word pix[%0d]: got %0d expected %0d", i, cap_a[i], exp); end
        end
        n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL first_word underflow: got %0b expected 0", underflow_a); end
    endtask

    task automatic test_line_addressing();
        logic [19:0] base;
        clear_mem();
        pulse_frame();
        acc_q.delete();
        for (int ln = 1; ln <= 5; ln++) begin
            run_line(1'b0);
            base = (ln == 5) ? 20'hA : 20'h0;
            n_checks++;
            if (acc_q.size() != 10) begin
                n_fail++; $display("FAIL line%0d request count: got %0d expected 10", ln, acc_q.size());
            end else begin
                for (int j = 0; j < 10; j++) begin
                    n_checks++;
                    if (acc_q[j] !== base + 20'(j)) begin n_fail++; $display("FAIL line%0d addr[%0d]: got %0h expected %0h", ln, j, acc_q[j], base + 20'(j)); end
                end
            end
            acc_q.delete();
        end
        n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL addressing underflow: got %0b expected 0", underflow_a); end
    endtask

    task automatic test_line_start_in_wait();
        bit ok;
        logic [1:0] exp;
        clear_mem();
        mem[0] = 16'hFFFF;
        pulse_frame();
        acc_q.delete();
        @(negedge clk50); line_start = 1'b1;
        @(negedge clk50); line_start = 1'b0;
        wait_accept(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wait_discard accept: got none expected 1 request"); end
        n_checks++; if (ok && acc_q[0] !== 20'h0) begin n_fail++; $display("FAIL wait_discard addr: got %0h expected 0", acc_q[0]); end
        mem[0] = 16'h0002;
        run_line(1'b0);
        for (int i = 0; i < 64; i++) begin
            exp = (i >= 4 && i < 8) ? 2'd1 : 2'd0;
            n_checks++;
            if (cap_a[i] !== exp) begin n_fail++; $display("FAIL wait_discard pix[%0d]: got %0d expected %0d", i, cap_a[i], exp); end
        end
    endtask

    task automatic test_bpp2();
        logic [1:0] exp;
        clear_mem();
        mem[0] = 16'h00E4;
        run_line(1'b1);
        for (int i = 0; i < 32; i++) begin
            exp = (i < 16) ? 2'(i / 4) : 2'd0;
            n_checks++;
            if (cap_b[i] !== exp) begin n_fail++; $display("FAIL bpp2 pix[%0d]: got %0d expected %0d", i, cap_b[i], exp); end
        end
        n_checks++; if (underflow_b !== 1'b0) begin n_fail++; $display("FAIL bpp2 underflow: got %0b expected 0", underflow_b); end
        n_checks++; if (ucnt_b !== 16'h0) begin n_fail++; $display("FAIL bpp2 underflow_cnt: got %0d expected 0", ucnt_b); end
    endtask

    task automatic test_underflow();
        int nonzero;
        logic [15:0] exp_cnt;
`ifdef FB_SCANOUT_UFLOW_CNT_EN
        exp_cnt = 16'd10;
`else
        exp_cnt = 16'd0;
`endif
        clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
        rdy_a = 1'b0;
        pulse_frame();
        run_line(1'b0);
        nonzero = 0;
        for (int i = 0; i < H; i++) if (cap_a[i] !== 2'd0) nonzero++;
        n_checks++; if (nonzero != 0) begin n_fail++; $display("FAIL underflow nonzero pixels: got %0d expected 0", nonzero); end
        n_checks++; if (underflow_a !== 1'b1) begin n_fail++; $display("FAIL underflow flag: got %0b expected 1", underflow_a); end
        n_checks++; if (ucnt_a !== exp_cnt) begin n_fail++; $display("FAIL underflow_cnt: got %0d expected %0d", ucnt_a, exp_cnt); end
        n_checks++; if (req_valid_a !== 1'b1) begin n_fail++; $display("FAIL underflow held req_valid: got %0b expected 1", req_valid_a); end
        n_checks++; if (req_addr_a !== 20'h0) begin n_fail++; $display("FAIL underflow held req_addr: got %0h expected 0", req_addr_a); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        logic [15:0] exp_cnt;
`ifdef FB_SCANOUT_UFLOW_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        mem[0] = 16'hFFFF;
        acc_q.delete();
        @(negedge clk50); rdy_a = 1'b1;
        wait_accept(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_wait accept: got none expected 1 request"); end
        reset = 1'b1;
        @(negedge clk50);
        n_checks++; if (req_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_wait req_valid: got %0b expected 0", req_valid_a); end
        n_checks++; if (pix_out_a !== 1'b0) begin n_fail++; $display("FAIL rst_wait pix_out: got %0b expected 0", pix_out_a); end
        n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL rst_wait underflow: got %0b expected 0", underflow_a); end
        n_checks++; if (ucnt_a !== 16'h0) begin n_fail++; $display("FAIL rst_wait underflow_cnt: got %0d expected 0", ucnt_a); end
        reset = 1'b0;
        repeat (10) @(negedge clk50);
        n_checks++; if (req_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_wait post-stray req_valid: got %0b expected 0", req_valid_a); end
        pix_en = 1'b1; in_display = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk50);
            n_checks++;
            if (pix_out_a !== 1'b0) begin n_fail++; $display("FAIL rst_wait stray pix[%0d]: got %0b expected 0", i, pix_out_a); end
        end
        pix_en = 1'b0; in_display = 1'b0;
        @(negedge clk50);
        n_checks++; if (underflow_a !== 1'b1) begin n_fail++; $display("FAIL rst_wait empty-fifo underflow: got %0b expected 1", underflow_a); end
        n_checks++; if (ucnt_a !== exp_cnt) begin n_fail++; $display("FAIL rst_wait underflow_cnt after pop: got %0d expected %0d", ucnt_a, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_line_addressing();
        test_line_start_in_wait();
        test_bpp2();
        test_underflow();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Parametrised framebuffer scanout engine for the Hack FPGA computer; next generation of the top-level pixel fetch/scaler logic. Fetches framebuffer words from the SDRAM manager through a valid/ready request port into a small prefetch FIFO. Serialises them into pixels with configurable bits-per-pixel and integer scale factor. Reports FIFO underflow instead of silently showing stale data.

## Interface
Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 20, memory word-address width
- BPP, 1, bits per pixel (1, 2, 4, 8; divides DATA_W)
- SCALE, 4, pixel and line repeat factor (power of 2, ≥1)
- H_ACTIVE, 640, visible screen pixels per line
- BASE_ADDR, 0, word address of framebuffer line 0
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2, ≥2)

Ports:
- clk50  in  1  sole clock; everything is synchronous to it
- reset  in  1  asynchronous, active-high
- pix_en  in  1  pixel-clock enable strobe
- in_display  in  1  current pixel is visible
- line_start  in  1  one-cycle pulse, start of horizontal blank before each visible line
- frame_start  in  1  one-cycle pulse during vertical blank
- req_valid  out  1  memory read request
- req_addr  out  ADDR_W  request word address
- req_ready  in  1  request accepted when high with req_valid
- rsp_valid  in  1  one-cycle read data strobe
- rsp_data  in  DATA_W  read data
- pix_out  out  BPP  pixel value
- underflow  out  1  sticky; FIFO empty when a word load was needed
- underflow_cnt  out  16  saturating underflow count (see Configuration)

## Operation
- Derived values:
  - WPL = H_ACTIVE/SCALE*BPP/DATA_W words per source line; 10 at defaults.
  - PPW = DATA_W/BPP pixels per word.
- Fetch FSM: IDLE, REQ, WAIT.
  - IDLE→REQ when word_idx < WPL and fifo_count + 1 ≤ FIFO_DEPTH.
  - REQ: req_valid=1, req_addr = line_base + word_idx. Address is stable until req_ready. On accept: word_idx++, →WAIT.
  - WAIT→IDLE on rsp_valid. Data is pushed unless the discard flag is set.
  - At most one request is outstanding.
- line_start:
  - Flush FIFO; word_idx=0.
  - If first_line=1: clear first_line; line_base is unchanged.
  - Else: vrep++. When vrep wraps from SCALE-1 to 0, line_base += WPL (mod 2^ADDR_W).
  - If in WAIT, set discard so the in-flight response is dropped. After that response, fetch resumes.
  - If in REQ, the request is held and req_addr is not changed until accepted. The accepted word is discarded and the fetch restarts at the new line_base.
- frame_start: line_base=BASE_ADDR, vrep=0, first_line=1, FIFO flushed, word_idx=WPL (fetching halts until line_start).
- frame_start and line_start in the same cycle: frame_start is applied first, then line_start. Fetch of line 0 starts immediately without advancing.
- Serialiser, on pix_en && in_display:
  - Output bits [BPP-1:0] of the shift register, LSB-first, so bit 0 is the leftmost pixel.
  - hrep counts 0..SCALE-1; on wrap, shift right by BPP.
  - After PPW shifts, pop the next word.
  - First pixel of a line: the word pops on the first visible pix_en, so that word's pixels are output from that pixel on.
  - If the FIFO is empty at a pop: pix_out=0 for that word's span, underflow set.
- Outside display: pix_out=0; serialiser position resets on line_start.
- Reset values: req_valid=0, req_addr=0, pix_out=0, underflow=0, underflow_cnt=0, FSM IDLE, FIFO empty, first_line=1, word_idx=WPL.

## Timing
- pix_out is registered: valid 1 clk50 after the qualifying pix_en.
- Fetch throughput is one word per request/response round trip.
- line_start must lead the first visible pixel by enough cycles to fill at least one word. The bench guarantees ≥ 4×(memory latency+2).
- rsp_valid never arrives in the same cycle as the accepting req_ready.
- Reset asserted mid-WAIT: everything returns to reset values. A stray later rsp_valid in IDLE is ignored.

## Configuration
- FB_SCANOUT_UFLOW_CNT_EN defined: underflow_cnt increments once per underflowing pop, saturating at 16'hFFFF, cleared only by reset.
- Not defined: the counter logic is omitted and underflow_cnt is tied to 0; the sticky underflow flag remains.

## Structure
- Package fb_scanout_pkg holds:
  - the fetch FSM state enum;
  - a clog2 function;
  - derived localparam functions for WPL and PPW.
- Sub-module fb_scanout_fifo: synchronous FIFO with flush, count output, parametrised by DATA_W and FIFO_DEPTH.

## Test plan
- Reset asserted while in WAIT → next cycle req_valid=0, pix_out=0, underflow=0; a later rsp_valid has no effect.
- frame_start, line_start; memory returns 16'h0001 at BASE_ADDR → first 4 visible pixels=1, next 60 pixels=0.
- Defaults, 5 line_starts after frame_start → lines 1–4 request 0x0–0x9 each; line 5 requests 0xA–0x13.
- req_ready held low across a visible line → pix_out=0, underflow=1, underflow_cnt=10 with the macro (0 without).
- line_start while in WAIT → in-flight 16'hFFFF discarded; first pixel of the new line comes from the newly fetched word.
- BPP=2, word 16'h00E4 → pixel values 0,1,2,3 each held 4 pixels, then 0s.
